// File: rtl/incubator_dcu.sv
// Incubator control: Moore FSM (heat / idle / three cooling levels) with hysteresis, plus a registered alarm.
// Latency: outputs follow the sampling edge by one clock. No backpressure. Sticky alarm under DCU_ALARM_LATCH_EN.
module incubator_dcu #(
  parameter logic signed [7:0] T_HEAT_ON  = 8'sd15,
  parameter logic signed [7:0] T_HEAT_OFF = 8'sd30,
  parameter logic signed [7:0] T_COOL_ON  = 8'sd35,
  parameter logic signed [7:0] T_COOL_OFF = 8'sd25,
  parameter logic signed [7:0] T_COOL2    = 8'sd40,
  parameter logic signed [7:0] T_COOL3    = 8'sd45,
  parameter logic signed [7:0] T_ALARM_LO = 8'sd0,
  parameter logic signed [7:0] T_ALARM_HI = 8'sd50,
  parameter logic [3:0]        CRS_L1     = 4'd4,
  parameter logic [3:0]        CRS_L2     = 4'd6,
  parameter logic [3:0]        CRS_L3     = 4'd8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic signed [7:0] T,
  output logic              Heater,
  output logic              Cooler,
  output logic              OUT,
  output logic [3:0]        CRS
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAT  = 3'd1,
    S_COOL1 = 3'd2,
    S_COOL2 = 3'd3,
    S_COOL3 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_out;
  logic   w_alarm;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // One level per edge; a hot sample in HEAT passes through IDLE first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (T < T_HEAT_ON)      w_next = S_HEAT;
        else if (T > T_COOL_ON) w_next = S_COOL1;
      end
      S_HEAT: begin
        if (T >= T_HEAT_OFF) w_next = S_IDLE;
      end
      S_COOL1: begin
        if (T > T_COOL2)         w_next = S_COOL2;
        else if (T < T_COOL_OFF) w_next = S_IDLE;
      end
      S_COOL2: begin
        if (T > T_COOL3)        w_next = S_COOL3;
        else if (T < T_COOL_ON) w_next = S_COOL1;
      end
      S_COOL3: begin
        if (T < T_COOL2) w_next = S_COOL2;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Heater = 1'b0;
    Cooler = 1'b0;
    CRS    = 4'd0;
    case (r_state)
      S_HEAT:  Heater = 1'b1;
      S_COOL1: begin Cooler = 1'b1; CRS = CRS_L1; end
      S_COOL2: begin Cooler = 1'b1; CRS = CRS_L2; end
      S_COOL3: begin Cooler = 1'b1; CRS = CRS_L3; end
      default: ;
    endcase
  end

  assign w_alarm = (T < T_ALARM_LO) || (T > T_ALARM_HI);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_out <= 1'b0;
    end else begin
`ifdef DCU_ALARM_LATCH_EN
      r_out <= r_out | w_alarm;
`else
      r_out <= w_alarm;
`endif
    end
  end

  assign OUT = r_out;

endmodule

// File: tb/tb_incubator_dcu.sv
// Bench for incubator_dcu: level-based reference model checked every cycle, plus directed literal expectations.
module tb_incubator_dcu;

`ifdef DCU_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic              clk;
  logic              rstN;
  logic signed [7:0] T;
  logic              Heater;
  logic              Cooler;
  logic              OUT;
  logic [3:0]        CRS;

  int checks   = 0;
  int failures = 0;
  bit ce       = 1'b0;

  incubator_dcu dut (
    .clk   (clk),
    .rstN  (rstN),
    .T     (T),
    .Heater(Heater),
    .Cooler(Cooler),
    .OUT   (OUT),
    .CRS   (CRS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode -1 = heating, 0 = idle, 1..3 = cooling level.
  int up_th  [0:2] = '{35, 40, 45};
  int dn_th  [1:3] = '{25, 35, 40};
  int crs_tab[0:3] = '{0, 4, 6, 8};
  int m_mode;
  bit m_out;
  bit seen_out;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_mode <= 0;
      m_out  <= 1'b0;
    end else begin
      if (m_mode == -1) begin
        if (T >= 30) m_mode <= 0;
      end else if (m_mode < 3 && T > up_th[m_mode]) begin
        m_mode <= m_mode + 1;
      end else if (m_mode > 0 && T < dn_th[m_mode]) begin
        m_mode <= m_mode - 1;
      end else if (m_mode == 0 && T < 15) begin
        m_mode <= -1;
      end
      m_out <= (LATCH && m_out) || (T < 0) || (T > 50);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ce && rstN) begin
      chk("m_heater", Heater, (m_mode == -1) ? 1 : 0);
      chk("m_cooler", Cooler, (m_mode > 0) ? 1 : 0);
      chk("m_crs", CRS, (m_mode > 0) ? crs_tab[m_mode] : 0);
      chk("m_out", OUT, m_out);
      chk("m_excl", Heater & Cooler, 0);
      chk("m_crs_legal", (CRS == 0 || CRS == 4 || CRS == 6 || CRS == 8) ? 1 : 0, 1);
      if (LATCH && seen_out) chk("out_sticky", OUT, 1);
      if (OUT) seen_out = 1'b1;
    end
    if (!rstN) seen_out = 1'b0;
  end

  task automatic step(input int t);
    T = 8'(t);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rstN = 1'b0;
    #1;
    chk("rst_async_heater", Heater, 0);
    chk("rst_async_cooler", Cooler, 0);
    chk("rst_async_crs", CRS, 0);
    chk("rst_async_out", OUT, 0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0;
    T    = -8'sd11;
    #12;
    chk("rst_heater", Heater, 0);
    chk("rst_cooler", Cooler, 0);
    chk("rst_crs", CRS, 0);
    chk("rst_out", OUT, 0);
    @(negedge clk);
    rstN = 1'b1;
    ce   = 1'b1;
    step(-11);
    chk("rel_heater", Heater, 1);
    chk("rel_out", OUT, 1);

    // Heating hysteresis
    step(10);  chk("heat_10", Heater, 1);
    step(20);  chk("heat_20", Heater, 1);
    step(30);  chk("heat_30_exit", Heater, 0);

    // Cooling ramp
    step(59);  chk("ramp_crs1", CRS, 4); chk("ramp_cooler", Cooler, 1); chk("ramp_out", OUT, 1);
    step(59);  chk("ramp_crs2", CRS, 6);
    step(59);  chk("ramp_crs3", CRS, 8);
    step(59);  chk("ramp_crs3_hold", CRS, 8);

    // Cooling descent
    step(20);  chk("desc_crs2", CRS, 6);
    step(20);  chk("desc_crs1", CRS, 4);
    step(20);  chk("desc_crs0", CRS, 0); chk("desc_cooler", Cooler, 0);
    step(20);  chk("desc_heater", Heater, 0);

    // Mid-operation reset
    step(40);  chk("pre_rst_cooler", Cooler, 1);
    pulse_reset();

    // Boundaries (alarm-free values first so literals hold in both alarm modes)
    step(0);   chk("bnd_out_0", OUT, 0); chk("bnd_0_heat", Heater, 1);
    step(50);  chk("bnd_out_50", OUT, 0); chk("bnd_50_heat_exit", Heater, 0);
    step(35);  chk("bnd_35_idle", Cooler, 0);
    step(36);  chk("bnd_36_cool", Cooler, 1);
    step(-1);  chk("bnd_out_m1", OUT, 1); chk("bnd_m1_cool_exit", Cooler, 0);
    step(15);  chk("bnd_15_idle", Heater, 0);
    step(51);  chk("bnd_out_51", OUT, 1); chk("bnd_51_cool", CRS, 4);
    step(25);  chk("bnd_25_stay", CRS, 4);
    step(-128); chk("bnd_m128_out", OUT, 1); chk("bnd_m128_idle", Cooler, 0);
    step(127); chk("bnd_127_out", OUT, 1); chk("bnd_127_cool", CRS, 4);

    // Random walk, reference model checks every cycle
    pulse_reset();
    void'($urandom(32'd20240611));
    for (int i = 0; i < 64; i++) begin
      T = 8'($urandom_range(70, 0) - 11);
      repeat (5) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
